mem_port_arbiter: RTL and testbench

//  Shares the CPU's single Avalon memory master between the instruction-fetch requester (IF) and the load/store requester (LS).

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_rr_picker.sv | 29 ++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> BUS -> RESP -> IDLE)
//   port_t      : requester identity (instruction fetch / load-store)
//   IF_BE       : byte enables used for every instruction-fetch read
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_t;

    localparam logic [3:0] IF_BE = 4'b1111;

endpackage

// File: rtl/mem_rr_picker.sv
// mem_rr_picker
// Combinational two-way round-robin choice between the IF and LS requesters.
// Ports:
//   if_req, ls_req : incoming requests
//   last_grant     : port granted most recently
//   winner         : selected port (meaningful only when valid=1)
//   valid          : at least one request present
module mem_rr_picker
    import mem_arb_pkg::*;
(
    input  logic  if_req,
    input  logic  ls_req,
    input  port_t last_grant,
    output port_t winner,
    output logic  valid
);

    always_comb begin
        valid  = if_req | ls_req;
        winner = PORT_IF;
        if (if_req && ls_req) begin
            // Contention: the port that did not win last time goes first.
            winner = (last_grant == PORT_IF) ? PORT_LS : PORT_IF;
        end else if (ls_req) begin
            winner = PORT_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one Avalon memory master between the instruction-fetch (IF) and
// load/store (LS) requesters. One transfer at a time: the winner's command
// is latched in IDLE, driven on the bus in BUS until waitrequest drops, and
// acknowledged with a one-cycle ack in RESP.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   if_req/if_addr             : IF read request (held until if_ack)
//   if_ack/if_rdata            : IF completion pulse and read data
//   ls_req/ls_we/ls_addr/
//   ls_wdata/ls_be             : LS request and payload (held until ls_ack)
//   ls_ack/ls_rdata/ls_err     : LS completion pulse, read data, abort flag
//   mem_*/waitrequest          : Avalon master interface
// Configuration:
//   MEM_TIMEOUT_EN : when defined, a transfer stalled by waitrequest for
//                    TIMEOUT_CYCLES consecutive cycles is aborted (LS gets
//                    ls_err, IF gets zero read data). Undefined: BUS waits
//                    indefinitely and ls_err is tied 0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [3:0]  ls_be,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        waitrequest
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    port_t       r_last_grant;
    port_t       r_port;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_if_rdata;
    logic [31:0] r_ls_rdata;
    port_t       w_winner;
    logic        w_valid;
    logic        w_done;
    logic        w_abort;

    mem_rr_picker u_picker (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .valid      (w_valid)
    );

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_aborted;

    // Abort on the TIMEOUT_CYCLES-th consecutive stalled BUS cycle.
    assign w_abort = (r_state == BUS) && waitrequest &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_aborted  <= 1'b0;
        end else if (r_state == IDLE) begin
            r_wait_cnt <= '0;
            r_aborted  <= 1'b0;
        end else if (r_state == BUS) begin
            if (waitrequest) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_aborted <= w_abort;
        end
    end

    assign ls_err = (r_state == RESP) && (r_port == PORT_LS) && r_aborted;
`else
    logic [CNT_W-1:0] w_unused_timeout;
    assign w_unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign w_abort          = 1'b0;
    assign ls_err           = 1'b0;
`endif

    assign w_done = (r_state == BUS) && (!waitrequest || w_abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_next = BUS;
            BUS:     if (w_done)  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Command latch and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_IF;
            r_port       <= PORT_IF;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_last_grant <= w_winner;
                r_port       <= w_winner;
                if (w_winner == PORT_IF) begin
                    r_we    <= 1'b0;
                    r_addr  <= if_addr & ~32'h3;
                    r_wdata <= '0;
                    r_be    <= IF_BE;
                end else begin
                    r_we    <= ls_we;
                    r_addr  <= ls_addr & ~32'h3;
                    r_wdata <= ls_wdata;
                    r_be    <= ls_be;
                end
            end
            if (w_done && !r_we) begin
                // An aborted IF read returns zero; an aborted LS read keeps
                // its old data and is flagged through ls_err instead.
                if (r_port == PORT_IF) begin
                    r_if_rdata <= w_abort ? 32'h0 : mem_readdata;
                end else if (!w_abort) begin
                    r_ls_rdata <= mem_readdata;
                end
            end
        end
    end

    // Strobes derive from the state register so reset removes them at once.
    assign mem_read       = (r_state == BUS) && !r_we;
    assign mem_write      = (r_state == BUS) &&  r_we;
    assign mem_address    = r_addr;
    assign mem_writedata  = r_wdata;
    assign mem_byteenable = r_be;

    assign if_ack   = (r_state == RESP) && (r_port == PORT_IF);
    assign ls_ack   = (r_state == RESP) && (r_port == PORT_LS);
    assign if_rdata = r_if_rdata;
    assign ls_rdata = r_ls_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata = '0;
    logic        waitrequest = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ack         (if_ack),
        .if_rdata       (if_rdata),
        .ls_req         (ls_req),
        .ls_we          (ls_we),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_be          (ls_be),
        .ls_ack         (ls_ack),
        .ls_rdata       (ls_rdata),
        .ls_err         (ls_err),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .waitrequest    (waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        do_reset();
        check_val("rst mem_read",  {31'b0, mem_read}, 32'h0);
        check_val("rst mem_write", {31'b0, mem_write}, 32'h0);
        check_val("rst mem_addr",  mem_address, 32'h0);
        check_val("rst acks",      {29'b0, if_ack, ls_ack, ls_err}, 32'h0);
        check_val("rst rdata",     if_rdata | ls_rdata, 32'h0);

        // 1: IF read, no stall, unaligned address.
        if_req = 1'b1; if_addr = 32'hBFC0_0003;
        mem_readdata = 32'h1234_5678; waitrequest = 1'b0;
        step();
        check_val("t1 mem_read",  {31'b0, mem_read}, 32'h1);
        check_val("t1 mem_write", {31'b0, mem_write}, 32'h0);
        check_val("t1 mem_addr",  mem_address, 32'hBFC0_0000);
        check_val("t1 mem_be",    {28'b0, mem_byteenable}, 32'hF);
        check_val("t1 if_ack0",   {31'b0, if_ack}, 32'h0);
        step();
        check_val("t1 if_ack",    {31'b0, if_ack}, 32'h1);
        check_val("t1 if_rdata",  if_rdata, 32'h1234_5678);
        check_val("t1 strobe off", {30'b0, mem_read, mem_write}, 32'h0);
        if_req = 1'b0;
        step();
        check_val("t1 ack once",  {30'b0, if_ack, ls_ack}, 32'h0);

        // 2: LS write stalled for three cycles.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_0040;
        ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0010; waitrequest = 1'b1;
        mem_readdata = 32'hAAAA_5555;
        step();
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t2 c%0d strobes", k), {30'b0, mem_read, mem_write}, 32'h1);
            check_val($sformatf("t2 c%0d addr", k),  mem_address, 32'h0000_0040);
            check_val($sformatf("t2 c%0d wdata", k), mem_writedata, 32'hDEAD_BEEF);
            check_val($sformatf("t2 c%0d be", k),    {28'b0, mem_byteenable}, 32'h2);
            check_val($sformatf("t2 c%0d noack", k), {31'b0, ls_ack}, 32'h0);
            if (k == 3) waitrequest = 1'b0;
            step();
        end
        check_val("t2 ls_ack",    {31'b0, ls_ack}, 32'h1);
        check_val("t2 rdata kept", ls_rdata, 32'h0);
        check_val("t2 strobe off", {30'b0, mem_read, mem_write}, 32'h0);
        ls_req = 1'b0;
        step();
        check_val("t2 ack once",  {31'b0, ls_ack}, 32'h0);

        // 6: LS read whose address changes after grant.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0100; ls_be = 4'hF;
        waitrequest = 1'b1; mem_readdata = 32'hCAFE_F00D;
        step();
        ls_addr = 32'h0000_0200;
        for (int k = 0; k < 3; k++) begin
            check_val($sformatf("t6 c%0d addr", k), mem_address, 32'h0000_0100);
            check_val($sformatf("t6 c%0d read", k), {31'b0, mem_read}, 32'h1);
            if (k == 2) waitrequest = 1'b0;
            step();
        end
        check_val("t6 ls_ack",   {31'b0, ls_ack}, 32'h1);
        check_val("t6 ls_rdata", ls_rdata, 32'hCAFE_F00D);
        check_val("t6 if_rdata kept", if_rdata, 32'h1234_5678);
        ls_req = 1'b0;
        step();

        // 3: both requesting continuously from reset -> LS, IF, LS, IF.
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000;
        waitrequest = 1'b0; mem_readdata = 32'h0;
        for (int t = 0; t < 4; t++) begin
            logic exp_ls;
            exp_ls = (t % 2 == 0);
            step();
            check_val($sformatf("t3 x%0d addr", t), mem_address,
                      exp_ls ? 32'h0000_2000 : 32'h0000_1000);
            check_val($sformatf("t3 x%0d acks idle", t), {30'b0, if_ack, ls_ack}, 32'h0);
            step();
            check_val($sformatf("t3 x%0d acks", t), {30'b0, if_ack, ls_ack},
                      exp_ls ? 32'h1 : 32'h2);
            step();
            check_val($sformatf("t3 x%0d acks gap", t), {30'b0, if_ack, ls_ack}, 32'h0);
        end
        if_req = 1'b0; ls_req = 1'b0;
        step();

        // 4: reset while stalled in BUS.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0300; waitrequest = 1'b1;
        step();
        check_val("t4 read before rst", {31'b0, mem_read}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t4 read dropped", {30'b0, mem_read, mem_write}, 32'h0);
        ls_req = 1'b0; waitrequest = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val($sformatf("t4 c%0d no ack", k), {30'b0, if_ack, ls_ack}, 32'h0);
        end

`ifdef MEM_TIMEOUT_EN
        // 5: LS read with waitrequest stuck high, timeout of 4.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0400; waitrequest = 1'b1;
        mem_readdata = 32'h7777_7777;
        step();
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("t5 c%0d read", k), {31'b0, mem_read}, 32'h1);
            step();
        end
        check_val("t5 read dropped", {31'b0, mem_read}, 32'h0);
        check_val("t5 ack+err", {30'b0, ls_ack, ls_err}, 32'h3);
        ls_req = 1'b0; waitrequest = 1'b0;
        step();
        check_val("t5 err once", {30'b0, ls_ack, ls_err}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Protocol watchdog: both strobes or both acks high at once is an error.
    always @(negedge clk) begin
        if (rst_n && ((mem_read && mem_write) || (if_ack && ls_ack))) begin
            check_val("excl strobes/acks", {28'b0, mem_read, mem_write, if_ack, ls_ack}, 32'h0);
        end
    end

endmodule
